// File: rtl/data_ram_ctrl.sv
// Data-memory controller for the memory-access stage: a word-organised RAM
// behind a wait-state sequencer that stalls the pipeline until each access completes.
module data_ram_ctrl #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stall_req_o,
    output logic        ready_o,
    output logic        align_err_o
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_we;
    logic                  r_mis;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_start;
    logic                  w_commit;
    logic                  w_mis_in;
    logic [DEPTH_LOG2-1:0] w_idx_in;
    logic                  w_unused_addr;

    // Upper address bits are deliberately dropped so the array aliases.
    assign w_idx_in      = mem_addr_i[DEPTH_LOG2+1:2];
    assign w_mis_in      = |mem_addr_i[1:0];
    assign w_unused_addr = ^mem_addr_i[31:DEPTH_LOG2+2];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_ce_i) begin
                    w_start      = 1'b1;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mem_ce_i) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_commit     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_start) begin
                r_idx   <= w_idx_in;
                r_we    <= mem_we_i;
                r_mis   <= w_mis_in;
                r_wdata <= mem_data_i;
            end
            if (w_commit && !r_we) begin
                r_rdata <= r_mis ? 32'h0 : r_mem[r_idx];
            end
        end
    end

    // No reset on the array; reset forces S_IDLE asynchronously, which blocks any commit.
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !r_mis) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign mem_data_o  = r_rdata;
    assign stall_req_o = mem_ce_i && (r_state != S_DONE);
    assign ready_o     = (r_state == S_DONE);
    assign align_err_o = (r_state == S_DONE) && r_mis;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench: two controllers (2 and 0 wait states) driven by directed and
// random accesses, checked against a word-array reference model.
module tb_data_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ce    [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        rdy   [2];
    logic        aerr  [2];

    data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]),
        .mem_addr_i(addr[0]), .mem_data_i(wdata[0]), .mem_data_o(rdata[0]),
        .stall_req_o(stall[0]), .ready_o(rdy[0]), .align_err_o(aerr[0])
    );

    data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]),
        .mem_addr_i(addr[1]), .mem_data_i(wdata[1]), .mem_data_o(rdata[1]),
        .stall_req_o(stall[1]), .ready_o(rdy[1]), .align_err_o(aerr[1])
    );

    typedef struct {
        int          inst;
        bit          is_store;
        bit          mis;
        bit          chk;
        logic [31:0] data;
        logic [31:0] a;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl_mem   [2][1024];
    bit          mdl_known [2][1024];
    logic [31:0] last_data [2];
    bit          last_known[2];

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    // Expected mem_data_o at completion: load result, or the held value for stores.
    function automatic exp_t predict(input int k, input bit w, input logic [31:0] a,
                                     input logic [31:0] d);
        exp_t e;
        int   idx;
        idx        = int'((a >> 2) % 1024);
        e.inst     = k;
        e.is_store = w;
        e.mis      = (a % 4) != 0;
        e.a        = a;
        if (w) begin
            if (!e.mis) begin
                mdl_mem[k][idx]   = d;
                mdl_known[k][idx] = 1'b1;
            end
            e.chk  = last_known[k];
            e.data = last_data[k];
        end else if (e.mis) begin
            e.chk  = 1'b1;
            e.data = 32'h0;
        end else begin
            e.chk  = mdl_known[k][idx];
            e.data = mdl_mem[k][idx];
        end
        if (!w) begin
            last_data[k]  = e.data;
            last_known[k] = e.chk;
        end
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that follows DONE.
    task automatic access(input int k, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble);
        int          lat;
        logic [31:0] r;
        lat      = wait_of(k) + 3;
        ce[k]    = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        sb_q.push_back(predict(k, w, a, d));
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk($sformatf("stall_i%0d_c%0d", k, c), 32'(stall[k]), 32'(c != lat));
            chk($sformatf("ready_i%0d_c%0d", k, c), 32'(rdy[k]), 32'(c == lat));
            if (c != lat) begin
                @(posedge clk);
                #1;
                if (scramble) begin
                    r        = $urandom;
                    we[k]    = r[0];
                    addr[k]  = $urandom;
                    wdata[k] = $urandom;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k, input int n);
        ce[k] = 1'b0;
        we[k] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flush(input int k, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int drop_c);
        ce[k]    = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        for (int c = 1; c <= drop_c; c++) begin
            @(negedge clk);
            chk($sformatf("flush_stall_i%0d_c%0d", k, c), 32'(stall[k]), 32'd1);
            chk($sformatf("flush_ready_i%0d_c%0d", k, c), 32'(rdy[k]), 32'd0);
            @(posedge clk);
            #1;
        end
        ce[k] = 1'b0;
        @(negedge clk);
        chk("flush_stall_low", 32'(stall[k]), 32'd0);
        chk("flush_no_ready", 32'(rdy[k]), 32'd0);
        if (last_known[k]) chk("flush_data_hold", rdata[k], last_data[k]);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        r = r & 32'hFFFF_F03F;
        if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
        return r;
    endfunction

    // Monitor: every completion pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (rdy[k] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready inst%0d: got ready=1 required ready=0", k);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_inst", 32'(k), 32'(e.inst));
                    chk("align_err", 32'(aerr[k]), 32'(e.mis));
                    if (e.chk) chk("mem_data", rdata[k], e.data);
                    $display("inst%0d %s addr=%08h mem_data_o=%08h align_err=%0b",
                             k, e.is_store ? "store" : "load ", e.a, rdata[k], aerr[k]);
                end
            end else if (aerr[k] === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL align_err_without_ready inst%0d: got 1 required 0", k);
            end
        end
    end

    initial begin
        int k;
        int n;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ce[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
            last_data[i] = 32'h0; last_known[i] = 1'b1;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", 32'(rdy[i]), 32'd0);
            chk("reset_align", 32'(aerr[i]), 32'd0);
            chk("reset_data", rdata[i], 32'h0);
            chk("reset_stall_ce0", 32'(stall[i]), 32'd0);
        end
        ce[0] = 1'b1;
        #1;
        chk("reset_stall_ce1", 32'(stall[0]), 32'd1);
        ce[0] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Store then load, 2 wait states
        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0); idle(0, 1);
        access(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);         idle(0, 1);
        // Address wrap-around
        access(0, 1'b1, 32'h0000_1004, 32'h1234_5678, 1'b0); idle(0, 1);
        access(0, 1'b0, 32'h0000_0004, 32'h0, 1'b0);         idle(0, 1);
        // Misaligned accesses
        access(0, 1'b1, 32'h0000_0020, 32'h5A5A_1234, 1'b0); idle(0, 1);
        access(0, 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0); idle(0, 1);
        access(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0);         idle(0, 1);
        access(0, 1'b0, 32'h0000_0023, 32'h0, 1'b0);         idle(0, 1);
        // Flush in the second wait cycle
        access(0, 1'b1, 32'h0000_0030, 32'h0F0F_0F0F, 1'b0); idle(0, 1);
        flush(0, 1'b1, 32'h0000_0030, 32'hAAAA_5555, 2);     idle(0, 1);
        access(0, 1'b0, 32'h0000_0030, 32'h0, 1'b0);         idle(0, 1);

        // Reset in the middle of a store
        access(0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b0); idle(0, 1);
        ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0040; wdata[0] = 32'h7777_7777;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_data0", rdata[0], 32'h0);
        chk("rst_data1", rdata[1], 32'h0);
        chk("rst_stall_follows_ce", 32'(stall[0]), 32'd1);
        ce[0] = 1'b0;
        #1;
        chk("rst_stall_ce_low", 32'(stall[0]), 32'd0);
        for (int i = 0; i < 2; i++) begin
            last_data[i]  = 32'h0;
            last_known[i] = 1'b1;
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        access(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);         idle(0, 1);
        access(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);         idle(0, 1);

        // Zero wait states, back-to-back
        access(1, 1'b1, 32'h0000_0010, 32'h1111_0010, 1'b0);
        access(1, 1'b1, 32'h0000_0014, 32'h2222_0014, 1'b0); idle(1, 1);
        access(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        access(1, 1'b0, 32'h0000_0014, 32'h0, 1'b0);         idle(1, 1);

        // Randomised traffic with input scrambling, chains and flushes
        for (int i = 0; i < 120; i++) begin
            k = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) begin
                flush(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                      $urandom_range(1, wait_of(k) + 1));
                idle(k, 1);
            end else begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    access(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b1);
                end
                idle(k, $urandom_range(1, 2));
            end
        end

        idle(0, 1);
        idle(1, 1);
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
